// File: rtl/pin_echo_pkg.sv
// ---------------------------------------------------------------------------
// pin_echo_pkg
//   Shared types for the pin-echo loopback stage.
//   - echo_mode_e  : transform applied to the sampled pins
//   - echo_state_e : FLUSH while the delay line refills after a config change,
//                    RUN once the output reflects the current config
//   - clamp_u      : saturating helper used to clamp the requested delay
// ---------------------------------------------------------------------------
package pin_echo_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    PASS   = 2'd0,
    INVERT = 2'd1,
    HOLD   = 2'd2,
    COUNT  = 2'd3
  } echo_mode_e;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } echo_state_e;

  function automatic int unsigned clamp_u(input int unsigned v, input int unsigned hi);
    return (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/echo_delay_line.sv
// ---------------------------------------------------------------------------
// echo_delay_line
//   DEPTH-stage shift register with a selectable tap. i_sel = 0 returns the
//   input itself (no extra delay); i_sel = k returns the value that entered
//   k clocks ago. The caller keeps i_sel within 0..DEPTH.
// Ports
//   clk     in  1      rising-edge clock
//   rst_n   in  1      asynchronous active-low clear of all stages
//   i_data  in  W      value shifted in every edge
//   i_sel   in  DLY_W  tap select
//   o_tap   out W      selected tap (combinational)
// ---------------------------------------------------------------------------
module echo_delay_line #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int DLY_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i_data,
  input  logic [DLY_W-1:0] i_sel,
  output logic [W-1:0]     o_tap
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  always_comb begin
    o_tap = i_data;
    for (int i = 1; i <= DEPTH; i++) begin
      if (i_sel == DLY_W'(i)) o_tap = r_stage[i-1];
    end
  end

endmodule

// File: rtl/pin_echo_pipe.sv
// ---------------------------------------------------------------------------
// pin_echo_pipe
//   Pin-echo stage for the FPGA loopback harness. Samples the digital input
//   bus, applies a mode transform, delays it by d extra clocks and drives the
//   registered analog output. A sample taken at edge N is visible after edge
//   N+d (d = 0 is a plain one-register echo).
//   Config (mode, delay) is taken by a valid/ready handshake; every accepted
//   config, even an identical one, starts a flush of d+1 edges during which
//   analog_valid is low while the delay line refills.
// Optional feature
//   PIN_ECHO_PARITY_EN : adds analog_par, even parity of analog, registered
//                        and frozen together with analog.
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   digital      in   IN_W   sampled input pins (low OUT_W bits echoed)
//   cfg_valid    in   1      new config offered
//   cfg_ready    out  1      config accepted on cfg_valid & cfg_ready
//   cfg_mode     in   2      PASS / INVERT / HOLD / COUNT
//   cfg_delay    in   DLY_W  extra delay, clamped to DEPTH
//   analog       out  OUT_W  registered output pins
//   analog_valid out  1      analog reflects the current config
//   analog_par   out  1      (PIN_ECHO_PARITY_EN only) even parity of analog
// ---------------------------------------------------------------------------
module pin_echo_pipe
  import pin_echo_pkg::*;
#(
  parameter  int IN_W  = 12,
  parameter  int OUT_W = 6,
  parameter  int DEPTH = 4,
  localparam int DLY_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   digital,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [DLY_W-1:0]  cfg_delay,
  output logic [OUT_W-1:0]  analog,
  output logic              analog_valid
`ifdef PIN_ECHO_PARITY_EN
  ,
  output logic              analog_par
`endif
);

  echo_state_e      r_state;
  echo_mode_e       r_mode;
  logic [DLY_W-1:0] r_d;
  logic [DLY_W-1:0] r_flush;
  logic             r_cfg_ready;
  logic             r_valid;
  logic [OUT_W-1:0] r_cnt;
  logic             r_prev_bit;
  logic [OUT_W-1:0] r_analog;

  logic [OUT_W-1:0] w_din;
  logic [OUT_W-1:0] w_x;
  logic [OUT_W-1:0] w_tap;
  logic [DLY_W-1:0] w_d_new;
  echo_mode_e       w_mode_new;
  logic             w_hs;
  logic             w_unused_hi;

  // Low OUT_W pins are echoed; zero-extend when the output is wider.
  if (OUT_W <= IN_W) begin : gen_trunc
    assign w_din = digital[OUT_W-1:0];
  end else begin : gen_zext
    assign w_din = {{(OUT_W-IN_W){1'b0}}, digital};
  end

  // Upper input pins are not echoed.
  assign w_unused_hi = ^digital;

  assign w_hs       = cfg_valid & r_cfg_ready;
  assign w_mode_new = echo_mode_e'(cfg_mode);
  assign w_d_new    = DLY_W'(clamp_u(32'(cfg_delay), 32'(DEPTH)));

  // Delay-line input. HOLD feeds plain PASS data so the line is already
  // primed with live samples when leaving HOLD.
  always_comb begin
    w_x = w_din;
    case (r_mode)
      INVERT:  w_x = ~w_din;
      COUNT:   w_x = r_cnt;
      default: w_x = w_din;
    endcase
  end

  echo_delay_line #(
    .W     (OUT_W),
    .DEPTH (DEPTH),
    .DLY_W (DLY_W)
  ) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_x),
    .i_sel  (r_d),
    .o_tap  (w_tap)
  );

  // Control FSM: FLUSH counts down the refill time, RUN accepts config.
  // cfg_ready/analog_valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FLUSH;
      r_flush     <= '0;
      r_mode      <= PASS;
      r_d         <= '0;
      r_cfg_ready <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        FLUSH: begin
          if (r_flush == '0) begin
            r_state     <= RUN;
            r_cfg_ready <= 1'b1;
            r_valid     <= 1'b1;
          end else begin
            r_flush <= r_flush - DLY_W'(1);
          end
        end
        RUN: begin
          if (w_hs) begin
            r_mode      <= w_mode_new;
            r_d         <= w_d_new;
            r_flush     <= w_d_new;
            r_state     <= FLUSH;
            r_cfg_ready <= 1'b0;
            r_valid     <= 1'b0;
          end
        end
        default: begin
          r_state     <= FLUSH;
          r_cfg_ready <= 1'b0;
          r_valid     <= 1'b0;
        end
      endcase
    end
  end

  // Edge counter on digital[0]. Entering COUNT restarts it from zero with a
  // zero prior bit, so the first high sample counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_prev_bit <= 1'b0;
    end else if (w_hs && (w_mode_new == COUNT)) begin
      r_cnt      <= '0;
      r_prev_bit <= 1'b0;
    end else begin
      r_prev_bit <= digital[0];
      if ((r_mode == COUNT) && (digital[0] != r_prev_bit)) r_cnt <= r_cnt + OUT_W'(1);
    end
  end

  // Output register, frozen while in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_analog <= '0;
    end else if (r_mode != HOLD) begin
      r_analog <= w_tap;
    end
  end

`ifdef PIN_ECHO_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (r_mode != HOLD) begin
      r_par <= ^w_tap;
    end
  end

  assign analog_par = r_par;
`endif

  assign analog       = r_analog;
  assign analog_valid = r_valid;
  assign cfg_ready    = r_cfg_ready;

endmodule
